bin2dec_seq: RTL
================

# bin2dec_seq

Sequential binary-to-decimal display controller. It replaces the per-digit divide/modulo datapath feeding the six seven-segment digits with a 32-cycle shift-add-3 (double-dabble) converter that has a start/busy/done handshake. Registered BCD digits drive six existing `sevenseg` instances. It sits between the Y86 core's debug/status value (PC, register, memory word) and the board's HEX displays.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request conversion of `in_num`. Sampled only when idle.
- `in_num` input 32: unsigned binary value. Captured on the accepting edge.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when new digits are valid.
- `overflow` output 1: last converted value was > 999999.
- `digit5`..`digit0` output 4 each: BCD digits of the last result, most significant first. Held between conversions.
- `seg5`..`seg0` output 7 each: `sevenseg(digitN)`, combinational from the digit registers.

## Operation
- States:
  - IDLE: `busy`=0.
  - SHIFT: 32 iterations, 6-bit counter.
  - No separate DONE state; `done` is a registered pulse.
- IDLE, `start`=1:
  - Load `in_num` into the 32-bit binary shift register.
  - Clear the 40-bit BCD accumulator (10 digits).
  - Counter ← 0, go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1.
  - Counter++.
- After the 32nd shift:
  - Low 6 nibbles → `digit5..digit0`, i.e. `in_num` mod 10^6. Leading zeros are shown as 0.
  - `overflow` ← OR of upper 4 nibbles ≠ 0.
  - Return to IDLE.
- `start` while in SHIFT: ignored, not queued. `in_num` changes during SHIFT have no effect.
- Outputs change only at result-load edges or reset. `seg*` always reflect the `digit*` registers.

## Timing
Let T be the edge at which `start` is accepted.
- `busy` rises at T and falls at T+32.
- Shift edges are T+1..T+32.
- `done` rises at T+32 and falls at T+33.
- `digit*` and `overflow` update at T+32.
- Latency is 32 cycles. Minimum start-to-start interval is 33 cycles: `start` at edge T+32 is ignored because the state is still SHIFT; `start` at T+33 is accepted.
- `start` held high continuously gives back-to-back conversions every 33 cycles.
- Reset values:
  - `busy`=0, `done`=0, `overflow`=0.
  - `digit5..0`=0, so `seg*` show "0".
  - State IDLE.
- Reset mid-SHIFT:
  - Aborts the conversion; no `done`.
  - Digits are cleared at that edge.
- `rst` and `start` together: reset wins.

## Configuration
- `BIN2DEC_AUTO_EN` defined:
  - Adds a 32-bit `last_num` register, reset 0, loaded on every accept.
  - In IDLE, a conversion also starts without `start` whenever `in_num != last_num`.
  - `start` still forces a conversion.
  - Timing is identical to an explicit start.
- `BIN2DEC_AUTO_EN` not defined: no `last_num` register; conversions start only on `start`.

## Test plan
- Reset, then `start` with `in_num`=123456 at T:
  - `busy` high during T..T+32, `done` pulse at T+32.
  - Digits 1,2,3,4,5,6; `overflow`=0.
- `in_num`=0xFFFFFFFF (4294967295): digits 9,6,7,2,9,5; `overflow`=1.
- Boundaries:
  - 999999 → 9,9,9,9,9,9, `overflow`=0.
  - 1000000 → 0,0,0,0,0,0, `overflow`=1.
  - 0 → all 0, `overflow`=0.
- Re-request while busy:
  - Convert 555, then pulse `start` with 777 at T+5 and T+32: both ignored; result is 000555.
  - `start` with 777 at T+33: accepted, `done` at T+65 → 000777.
- Reset mid-conversion: `rst`=1 at T+10 → `busy`=0 next cycle, no `done`, digits 0, `overflow`=0.
- With `BIN2DEC_AUTO_EN`, `start` held 0:
  - After reset, set `in_num`=42 → conversion starts, result 000042 with a `done` pulse.
  - Holding 42 for 100 cycles → no further `done`.

Source files
------------

// File: rtl/bin2dec_seq.sv
// bin2dec_seq: sequential binary-to-decimal display controller.
// A 32-bit unsigned value is converted by a 32-cycle shift-add-3
// (double-dabble) loop into ten BCD nibbles. The low six nibbles are
// registered as digit5..digit0 and drive six sevenseg decoders.
// The upper four nibbles only feed the overflow flag.
// Optional build macro: BIN2DEC_AUTO_EN. When it is defined, a new
// conversion also starts whenever in_num differs from the last accepted
// value.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start (or a changed in_num in auto mode), busy=0
// SHIFT | 32 add-3/shift iterations; results load on the last one

module sevenseg (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Active-low gfedcba decode; non-BCD codes blank the digit.
   always_comb begin
      seg = 7'b1111111;
      case (digit)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

module bin2dec_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in_num,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [3:0]  digit5,
   output logic [3:0]  digit4,
   output logic [3:0]  digit3,
   output logic [3:0]  digit2,
   output logic [3:0]  digit1,
   output logic [3:0]  digit0,
   output logic [6:0]  seg5,
   output logic [6:0]  seg4,
   output logic [6:0]  seg3,
   output logic [6:0]  seg2,
   output logic [6:0]  seg1,
   output logic [6:0]  seg0
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state;
   state_t      nextState;
   logic [31:0] binReg;
   logic [39:0] bcdReg;
   logic [5:0]  count;
   logic        accept;
   logic        lastShift;
   logic        autoReq;
   logic [39:0] bcdAdj;
   logic [39:0] bcdNext;
   logic [31:0] binNext;

`ifdef BIN2DEC_AUTO_EN
   logic [31:0] lastNum;

   // Remember the last accepted operand so an unchanged input does not retrigger.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastNum <= 32'd0;
      end else if (accept) begin
         lastNum <= in_num;
      end
   end

   assign autoReq = (in_num != lastNum);
`else
   assign autoReq = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; the 32nd shift (count==31) also returns to IDLE.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      lastShift = 1'b0;
      case (state)
         IDLE: begin
            if (start || autoReq) begin
               accept    = 1'b1;
               nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (count == 6'd31) begin
               lastShift = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

   // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
   always_comb begin
      bcdAdj = bcdReg;
      for (int i = 0; i < 10; i++) begin
         if (bcdReg[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
         end
      end
      bcdNext = {bcdAdj[38:0], binReg[31]};
      binNext = {binReg[30:0], 1'b0};
   end

   // Conversion datapath and result registers; results load on the final shift edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         binReg   <= 32'd0;
         bcdReg   <= 40'd0;
         count    <= 6'd0;
         done     <= 1'b0;
         overflow <= 1'b0;
         digit5   <= 4'd0;
         digit4   <= 4'd0;
         digit3   <= 4'd0;
         digit2   <= 4'd0;
         digit1   <= 4'd0;
         digit0   <= 4'd0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            binReg <= in_num;
            bcdReg <= 40'd0;
            count  <= 6'd0;
         end else if (state == SHIFT) begin
            binReg <= binNext;
            bcdReg <= bcdNext;
            count  <= count + 6'd1;
            if (lastShift) begin
               digit5   <= bcdNext[23:20];
               digit4   <= bcdNext[19:16];
               digit3   <= bcdNext[15:12];
               digit2   <= bcdNext[11:8];
               digit1   <= bcdNext[7:4];
               digit0   <= bcdNext[3:0];
               overflow <= |bcdNext[39:24];
               done     <= 1'b1;
            end
         end
      end
   end

   sevenseg seg5Inst (.digit(digit5), .seg(seg5));
   sevenseg seg4Inst (.digit(digit4), .seg(seg4));
   sevenseg seg3Inst (.digit(digit3), .seg(seg3));
   sevenseg seg2Inst (.digit(digit2), .seg(seg2));
   sevenseg seg1Inst (.digit(digit1), .seg(seg1));
   sevenseg seg0Inst (.digit(digit0), .seg(seg0));

endmodule
